// File: rtl/i2s_audio_rx.sv
// Oversampled I2S / left-justified serial audio receiver in the clk32 domain.
// Synchronises async bck/ws/din, deserialises WIDTH-bit slots, presents stereo pairs with a strobe.
module i2s_audio_rx #(
  parameter int WIDTH      = 16,
  parameter int DELAY      = 0,
  parameter int OFFSET_BIN = 1,
  parameter int TIMEOUT    = 256
) (
  input  logic             clk32,
  input  logic             reset_n,
  input  logic             i2s_bck,
  input  logic             i2s_ws,
  input  logic             i2s_din,
  output logic [WIDTH-1:0] audio_l,
  output logic [WIDTH-1:0] audio_r,
  output logic             sample_valid,
  output logic             locked,
  output logic             frame_err
);

  localparam int               CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    FIRST_BIT = CW'(1);
  localparam logic [CW-1:0]    LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [15:0]      TO_MAX    = 16'(TIMEOUT);
  localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] MSB_FLIP  = (OFFSET_BIN != 0) ? {1'b1, {(WIDTH-1){1'b0}}}
                                                             : {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic [1:0]       bck_sync_q;
  logic [1:0]       ws_sync_q;
  logic [1:0]       din_sync_q;
  logic             bck_prev_q;

  state_t           state_q;
  logic             ws_prev_q;
  logic             chan_q;
  logic [CW-1:0]    bitcnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] staging_q;
  logic [WIDTH-1:0] audio_l_q;
  logic [WIDTH-1:0] audio_r_q;
  logic             sample_valid_q;
  logic             locked_q;
  logic             frame_err_q;
  logic [1:0]       good_cnt_q;
  logic             left_seen_q;
  logic [15:0]      to_cnt_q;

  logic             bck_rise_s;
  logic             ws_smp_s;
  logic             din_smp_s;
  logic             ws_edge_s;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] commit_word_s;

  // ws and din are taken from the same synchroniser stage as bck so they line up with bck_rise
  assign bck_rise_s    = bck_sync_q[1] & ~bck_prev_q;
  assign ws_smp_s      = ws_sync_q[1];
  assign din_smp_s     = din_sync_q[1];
  assign ws_edge_s     = bck_rise_s & (ws_smp_s ^ ws_prev_q);
  assign shreg_d       = {shreg_q[WIDTH-2:0], din_smp_s};
  assign commit_word_s = shreg_d ^ MSB_FLIP;

  assign audio_l      = audio_l_q;
  assign audio_r      = audio_r_q;
  assign sample_valid = sample_valid_q;
  assign locked       = locked_q;
  assign frame_err    = frame_err_q;

  // Two-flop synchronisers for the serial pins plus bck edge history
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      bck_sync_q <= 2'b00;
      ws_sync_q  <= 2'b00;
      din_sync_q <= 2'b00;
      bck_prev_q <= 1'b0;
    end else begin
      bck_sync_q <= {bck_sync_q[0], i2s_bck};
      ws_sync_q  <= {ws_sync_q[0], i2s_ws};
      din_sync_q <= {din_sync_q[0], i2s_din};
      bck_prev_q <= bck_sync_q[1];
    end
  end

  // Slot FSM, word commit, lock tracking and bck watchdog
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= HUNT;
      ws_prev_q      <= 1'b0;
      chan_q         <= 1'b0;
      bitcnt_q       <= {CW{1'b0}};
      shreg_q        <= {WIDTH{1'b0}};
      staging_q      <= {WIDTH{1'b0}};
      audio_l_q      <= {WIDTH{1'b0}};
      audio_r_q      <= {WIDTH{1'b0}};
      sample_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      frame_err_q    <= 1'b0;
      good_cnt_q     <= 2'd0;
      left_seen_q    <= 1'b0;
      to_cnt_q       <= 16'd0;
    end else begin
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      if (bck_rise_s) begin
        to_cnt_q  <= 16'd0;
        ws_prev_q <= ws_smp_s;
        if (ws_edge_s) begin
          // An edge before the slot filled up is a short slot, even on the would-be last bit
          if (state_q == SKIP || state_q == SHIFT) begin
            frame_err_q <= 1'b1;
            good_cnt_q  <= 2'd0;
            locked_q    <= 1'b0;
            left_seen_q <= 1'b0;
          end
          chan_q <= ws_smp_s;
          if (DELAY != 0) begin
            state_q <= SKIP;
          end else begin
            shreg_q  <= {{(WIDTH-1){1'b0}}, din_smp_s};
            bitcnt_q <= FIRST_BIT;
            state_q  <= SHIFT;
          end
        end else begin
          case (state_q)
            SKIP: begin
              shreg_q  <= {{(WIDTH-1){1'b0}}, din_smp_s};
              bitcnt_q <= FIRST_BIT;
              state_q  <= SHIFT;
            end
            SHIFT: begin
              shreg_q  <= shreg_d;
              bitcnt_q <= bitcnt_q + FIRST_BIT;
              if (bitcnt_q == LAST_BIT) begin
                state_q <= DONE;
                if (chan_q) begin
                  audio_r_q      <= commit_word_s;
                  audio_l_q      <= staging_q;
                  sample_valid_q <= 1'b1;
                  left_seen_q    <= 1'b0;
                  if (left_seen_q && good_cnt_q != 2'd2) begin
                    good_cnt_q <= good_cnt_q + 2'd1;
                  end
                  locked_q <= (good_cnt_q == 2'd2) || (left_seen_q && good_cnt_q == 2'd1);
                end else begin
                  staging_q   <= commit_word_s;
                  left_seen_q <= 1'b1;
                end
              end
            end
            HUNT, DONE: state_q <= state_q;
            default:    state_q <= HUNT;
          endcase
        end
      end else if (to_cnt_q != TO_MAX) begin
        to_cnt_q <= to_cnt_q + 16'd1;
        if (to_cnt_q == TO_LAST) begin
          frame_err_q <= 1'b1;
          good_cnt_q  <= 2'd0;
          locked_q    <= 1'b0;
          left_seen_q <= 1'b0;
          state_q     <= HUNT;
        end
      end
    end
  end

endmodule
